// File: rtl/seq_detector_1101.sv
// Serial bit-stream detector for the fixed pattern 1101 (oldest bit first).
// Overlapping matches are reported; the pulse is registered, one cycle wide.
module seq_detector_1101 (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic detected
);

  // Each state names the longest suffix of the stream that is still a prefix of 1101.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    S_1   = 2'b01,
    S_11  = 2'b10,
    S_110 = 2'b11
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_detected;
  logic   w_detect_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_detected <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_detected <= w_detect_next;
    end
  end

  // NOTE: defaults are assigned before the case so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state  = IDLE;
    w_detect_next = 1'b0;
    case (r_state)
      IDLE:    w_next_state = din ? S_1  : IDLE;
      S_1:     w_next_state = din ? S_11 : IDLE;
      S_11:    w_next_state = din ? S_11 : S_110;
      S_110: begin
        // The closing 1 also starts the next candidate match.
        w_next_state  = din ? S_1 : IDLE;
        w_detect_next = din;
      end
      default: begin
        w_next_state  = IDLE;
        w_detect_next = 1'b0;
      end
    endcase
  end

  assign detected = r_detected;

endmodule

// File: tb/tb_seq_detector_1101.sv
// Self-checking bench for seq_detector_1101: directed scenarios plus a random
// stream compared against a bit-history reference model.
module tb_seq_detector_1101;

  logic clk;
  logic rst;
  logic din;
  logic detected;

  int total;
  int bad;

  // Reference model: the last four sampled bits and how many have been seen since reset.
  logic [3:0] m_hist;
  int         m_count;

  seq_detector_1101 dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .detected (detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_clear();
    m_hist  = 4'b0000;
    m_count = 0;
  endfunction

  // Drive one bit (caller is at a falling edge), let it be sampled, return at
  // the next falling edge with the model's expected output for that bit.
  task automatic step(input logic b, output logic exp);
    din = b;
    @(posedge clk);
    m_hist  = {m_hist[2:0], b};
    m_count = m_count + 1;
    exp     = (m_count >= 4) && (m_hist == 4'b1101);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse taken between edges; output must clear at once.
  task automatic pulse_reset(input string tag);
    #1 rst = 1'b1;
    din = 1'b0;
    #1;
    total++;
    if (detected !== 1'b0) begin
      bad++;
      $display("FAIL %s_async_clear: detected=%b required=0", tag, detected);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b0;
    model_clear();
    #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (detected !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: detected=%b required=0", c, detected);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      logic e;
      step(1'b0, e);
      total++;
      if (detected !== 1'b0) begin
        bad++;
        $display("FAIL reset_release[%0d]: detected=%b required=0", c, detected);
      end
    end
  endtask

  task automatic test_main_stream();
    logic [16:0] bits;
    logic [16:0] mask;
    bits = 17'b1_0110_1101_0111_0110; // bit i = din for cycle i
    mask = 17'b1_0010_0001_0001_0000; // pulses after bits 4, 8, 13, 16
    pulse_reset("main");
    for (int i = 0; i < 17; i++) begin
      logic e;
      step(bits[i], e);
      total++;
      if (detected !== mask[i]) begin
        bad++;
        $display("FAIL main_stream bit%0d: detected=%b required=%b", i, detected, mask[i]);
      end
    end
  endtask

  task automatic test_all_zeros();
    for (int i = 0; i < 8; i++) begin
      logic e;
      step(1'b0, e);
      total++;
      if (detected !== 1'b0) begin
        bad++;
        $display("FAIL all_zeros[%0d]: detected=%b required=0", i, detected);
      end
    end
  endtask

  task automatic test_after_reset();
    logic [3:0] bits;
    logic [3:0] want;
    bits = 4'b1011; // bit i: 1,1,0,1
    want = 4'b1000;
    pulse_reset("after_reset");
    for (int i = 0; i < 4; i++) begin
      logic e;
      step(bits[i], e);
      total++;
      if (detected !== want[i]) begin
        bad++;
        $display("FAIL after_reset bit%0d: detected=%b required=%b", i, detected, want[i]);
      end
    end
  endtask

  task automatic test_overlap_prefix();
    logic [4:0] bits;
    logic [4:0] want;
    bits = 5'b10111; // bit i: 1,1,1,0,1
    want = 5'b10000;
    pulse_reset("overlap");
    for (int i = 0; i < 5; i++) begin
      logic e;
      step(bits[i], e);
      total++;
      if (detected !== want[i]) begin
        bad++;
        $display("FAIL overlap_prefix bit%0d: detected=%b required=%b", i, detected, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic e;
    logic [3:0] tail;
    logic [3:0] want;
    // Reset while the pulse is high: it must drop before the next edge.
    pulse_reset("mid_pre");
    step(1'b1, e); step(1'b1, e); step(1'b0, e); step(1'b1, e);
    total++;
    if (detected !== 1'b1) begin
      bad++;
      $display("FAIL mid_pulse_before_reset: detected=%b required=1", detected);
    end
    pulse_reset("mid_pulse");
    // Partial prefix 110 must be forgotten across reset.
    step(1'b1, e); step(1'b1, e); step(1'b0, e);
    pulse_reset("mid_prefix");
    tail = 4'b1011; // bit i: 1,1,0,1
    want = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step(tail[i], e);
      total++;
      if (detected !== want[i]) begin
        bad++;
        $display("FAIL reset_mid bit%0d: detected=%b required=%b", i, detected, want[i]);
      end
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    pulse_reset("random");
    for (int i = 0; i < 600; i++) begin
      logic e;
      logic b;
      b = ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 149) == 0) pulse_reset("random_mid");
      step(b, e);
      total++;
      if (detected !== e) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random bit%0d: detected=%b required=%b", i, detected, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    din   = 1'b0;
    model_clear();
    test_reset();
    test_main_stream();
    test_all_zeros();
    test_after_reset();
    test_overlap_prefix();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
